// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction RAM loader.
package inst_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_BYTES      = 2;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
    StWrite,
    StChk,
    StDone
  } state_e;

endpackage

// File: rtl/byte_word_packer.sv
// Shifts bytes MSB-first into a 32-bit word; word_full flags the byte that completes it.
module byte_word_packer
  import inst_loader_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          shift,
  input  logic [7:0]                    byte_in,
  output logic [8*BYTES_PER_WORD-1:0]   word,
  output logic                          word_full
);

  localparam int unsigned IdxW = $clog2(BYTES_PER_WORD);

  logic [IdxW-1:0] idx_q;

  assign word_full = shift && (idx_q == IdxW'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
      word  <= '0;
    end else if (clear) begin
      idx_q <= '0;
    end else if (shift) begin
      idx_q <= idx_q + IdxW'(1);
      word  <= {word[8*BYTES_PER_WORD-9:0], byte_in};
    end
  end

endmodule

// File: rtl/inst_ram_loader.sv
// Fills inst_ram from a length-prefixed byte stream while holding the CPU in reset.
// Optional trailing XOR checksum byte when INST_LOADER_CHECKSUM_EN is defined.
module inst_ram_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_wr,
  output logic              cpu_hold
);

  localparam int unsigned LenW  = 8 * LEN_BYTES;
  localparam int unsigned Depth = 1 << ADDR_W;
`ifdef INST_LOADER_CHECKSUM_EN
  localparam state_e AfterData = StChk;
`else
  localparam state_e AfterData = StDone;
`endif

  state_e                      state_q, state_d;
  logic [LenW-1:0]             len_q, len_next;
  logic [8*BYTES_PER_WORD-1:0] word;
  logic                        accept, launch, shift, word_full, len_over, more;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]                  csum_q;
`endif

  assign accept   = in_valid && in_ready;
  assign launch   = start && (state_q == StIdle || state_q == StDone);
  assign shift    = accept && (state_q == StData);
  assign len_next = {len_q[LenW-9:0], in_data};
  assign len_over = 32'(len_next) > Depth;
  assign more     = (32'(words_wr) + 32'd1) < 32'(len_q);
  assign ram_din  = word;

  byte_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (launch),
    .shift     (shift),
    .byte_in   (in_data),
    .word      (word),
    .word_full (word_full)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StLenHi;
      StLenHi:        if (accept) state_d = StLenLo;
      StLenLo: begin
        if (accept) begin
          if (len_next == '0)  state_d = AfterData;
          else if (len_over)   state_d = StDone;
          else                 state_d = StData;
        end
      end
      StData:         if (word_full) state_d = StWrite;
      StWrite:        state_d = more ? StData : AfterData;
      StChk:          if (accept) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      in_ready <= 1'b0;
      ram_ena  <= 1'b0;
      ram_wea  <= 1'b0;
      ram_addr <= '0;
      busy     <= 1'b0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      words_wr <= '0;
      len_q    <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      in_ready <= state_d inside {StLenHi, StLenLo, StData, StChk};
      busy     <= !(state_d inside {StIdle, StDone});
      cpu_hold <= !(state_d inside {StIdle, StDone});
      ram_ena  <= (state_d == StWrite);
      ram_wea  <= (state_d == StWrite);
      if (state_d == StWrite) ram_addr <= words_wr[ADDR_W-1:0];
      if (launch) begin
        done     <= 1'b0;
        err      <= 1'b0;
        words_wr <= '0;
      end
      if (accept && (state_q == StLenHi || state_q == StLenLo)) len_q <= len_next;
      if (accept && state_q == StLenLo && len_over) err <= 1'b1;
      if (state_q == StWrite) words_wr <= words_wr + (ADDR_W + 1)'(1);
      if (state_d == StDone && state_q != StDone) done <= 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
      if (launch)     csum_q <= '0;
      else if (shift) csum_q <= csum_q ^ in_data;
      if (accept && state_q == StChk && in_data != csum_q) err <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_inst_ram_loader.sv
// Directed self-checking bench for inst_ram_loader (also covers INST_LOADER_CHECKSUM_EN builds).
module tb_inst_ram_loader;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready, ram_ena, ram_wea, busy, done, err, cpu_hold;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [ADDR_W:0]   words_wr;

  int          n_checks = 0;
  int          n_fail = 0;
  int          wr_count = 0;
  int          rdy_viol = 0;
  int          hold_count = 0;
  int          base_wr, base_hold;
  logic [31:0] mem [16];
  logic [7:0]  tb_xor;

  always #5 clk = ~clk;

  inst_ram_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ram_ena  (ram_ena),
    .ram_wea  (ram_wea),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .words_wr (words_wr),
    .cpu_hold (cpu_hold)
  );

  // RAM model and cycle counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (ram_wea) begin
      wr_count++;
      if (ram_addr < 16) mem[ram_addr[3:0]] = ram_din;
      if (in_ready) rdy_viol++;
    end
    if (cpu_hold) hold_count++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("send_ready_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = w[31-8*i -: 8];
      tb_xor = tb_xor ^ b;
      if (gaps) repeat ($urandom_range(1, 3)) @(negedge clk);
      send_byte(b);
    end
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  task automatic pulse_start();
    tb_xor = 8'h00;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_trailer();
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(tb_xor);
`endif
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("wait_done", done, 1);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_done", done, 0);
    check("rst_wea", ram_wea, 0);
    check("rst_words", words_wr, 0);
    reset = 1'b1;
    @(negedge clk);

    // Idle bytes must not be consumed.
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) @(negedge clk);
    check("idle_in_ready", in_ready, 0);
    check("idle_busy", busy, 0);

    // N=2 with start coincident with the first length byte.
    base_wr = wr_count;
    tb_xor  = 8'h00;
    start   = 1'b1;
    in_data = 8'h00;
    @(negedge clk);
    start = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_in_ready", in_ready, 1);
    send_len(16'h0002);
    send_word(32'h12345678, 1'b0);
    check("t1_lat_wea", ram_wea, 1);
    check("t1_lat_addr", ram_addr, 0);
    check("t1_lat_din", ram_din, 32'h12345678);
    send_word(32'h9ABCDEF0, 1'b0);
    send_trailer();
    wait_done();
    check("t1_mem0", mem[0], 32'h12345678);
    check("t1_mem1", mem[1], 32'h9ABCDEF0);
    check("t1_err", err, 0);
    check("t1_words", words_wr, 2);
    check("t1_writes", wr_count - base_wr, 2);
    check("t1_hold", cpu_hold, 0);
    check("t1_busy_end", busy, 0);

    // N=0: no writes, cpu_hold for the start gap plus two length bytes.
    base_wr   = wr_count;
    base_hold = hold_count;
    pulse_start();
    send_len(16'h0000);
    send_trailer();
    wait_done();
    check("t2_err", err, 0);
    check("t2_writes", wr_count - base_wr, 0);
`ifdef INST_LOADER_CHECKSUM_EN
    check("t2_hold_cycles", hold_count - base_hold, 4);
`else
    check("t2_hold_cycles", hold_count - base_hold, 3);
`endif

    // Length overflow: 0x0401 > 1024 words.
    base_wr = wr_count;
    pulse_start();
    check("t3_cleared_done", done, 0);
    send_len(16'h0401);
    wait_done();
    check("t3_err", err, 1);
    check("t3_words", words_wr, 0);
    check("t3_writes", wr_count - base_wr, 0);

    // Sparse in_valid, three words.
    base_wr = wr_count;
    pulse_start();
    check("t4_err_cleared", err, 0);
    send_len(16'h0003);
    send_word(32'hDEADBEEF, 1'b1);
    send_word(32'h01234567, 1'b1);
    send_word(32'hCAFEF00D, 1'b1);
    send_trailer();
    wait_done();
    check("t4_mem0", mem[0], 32'hDEADBEEF);
    check("t4_mem1", mem[1], 32'h01234567);
    check("t4_mem2", mem[2], 32'hCAFEF00D);
    check("t4_words", words_wr, 3);
    check("t4_writes", wr_count - base_wr, 3);
    check("t4_err", err, 0);
    check("ready_during_write", rdy_viol, 0);

    // Reset after five data bytes, then a fresh single-word load.
    pulse_start();
    send_len(16'h0003);
    send_word(32'hAABBCCDD, 1'b0);
    send_byte(8'hEE);
    reset = 1'b0;
    #1;
    check("t5_rst_ready", in_ready, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_hold", cpu_hold, 0);
    check("t5_rst_words", words_wr, 0);
    check("t5_rst_din", ram_din, 0);
    check("t5_rst_ena", ram_ena, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    pulse_start();
    send_len(16'h0001);
    send_word(32'h11223344, 1'b0);
    send_trailer();
    wait_done();
    check("t5_mem0", mem[0], 32'h11223344);
    check("t5_words", words_wr, 1);
    check("t5_err", err, 0);

`ifdef INST_LOADER_CHECKSUM_EN
    // 01^02^03^04 = 04.
    pulse_start();
    send_len(16'h0001);
    send_word(32'h01020304, 1'b0);
    send_byte(8'h04);
    wait_done();
    check("cs_good_err", err, 0);
    base_wr = wr_count;
    pulse_start();
    send_len(16'h0001);
    send_word(32'h01020304, 1'b0);
    send_byte(8'h05);
    wait_done();
    check("cs_bad_err", err, 1);
    check("cs_bad_mem0", mem[0], 32'h01020304);
    check("cs_bad_writes", wr_count - base_wr, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
